// File: rtl/noc_trace_capture_pkg.sv
// Shared definitions for the router debug blocks: capture state encoding and
// the default trace word width.
package noc_trace_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

  localparam int TRACE_W_DEF = 32;

endpackage

// File: rtl/noc_trace_capture_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// The read register only loads on a read, so it holds its value between reads.
module trace_capture_ram #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/noc_trace_capture.sv
// Trace capture buffer: records allocator trace words while armed, freezes a
// window around the first trigger and replays it oldest-first on request.
module noc_trace_capture
  import noc_trace_capture_pkg::*;
#(
  parameter int TRACE_W   = TRACE_W_DEF,
  parameter int DEPTH     = 64,
  parameter int POST_TRIG = 48,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic [TRACE_W-1:0] trace,
  input  logic               arm,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [TRACE_W-1:0] rd_data,
  output logic               rd_last,
  output logic               armed,
  output logic               triggered,
  output logic               captured,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   trig_offset
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] POST_C  = CNT_W'(POST_TRIG);
  localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(DEPTH - 1 - POST_TRIG);

  // Handshake: rd_en is a request, accepted only in DONE while words remain
  // and arm is low; the word appears with rd_valid exactly one cycle later.
  // There is no backpressure on the read side.

  trace_state_e state, next_state;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] pre_cnt, post_cnt, rd_cnt;
  logic [CNT_W-1:0] trig_cur, sc_next;
  logic             we, rd_accept, enter_done;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (arm) begin
      next_state = ST_ARMED;
    end else begin
      case (state)
        ST_ARMED: if (trigger) next_state = (POST_TRIG == 0) ? ST_DONE : ST_POST;
        ST_POST:  if (post_cnt == CNT_W'(1)) next_state = ST_DONE;
        default:  next_state = state;
      endcase
    end
  end

  assign armed      = (state == ST_ARMED);
  assign triggered  = (state == ST_POST);
  assign captured   = (state == ST_DONE);
  assign we         = (armed || triggered) && !arm;
  assign rd_accept  = captured && rd_en && !arm && (rd_cnt < sample_count);
  assign enter_done = (next_state == ST_DONE) && (state != ST_DONE);

  // With POST_TRIG=0 the trigger offset is latched on the same edge we enter
  // DONE, so the window size must be formed from the live pre-count.
  assign trig_cur = armed ? pre_cnt : trig_offset;
  assign sc_next  = trig_cur + CNT_W'(1) + POST_C;

  always_ff @(posedge clk) begin
    if (reset || arm) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pre_cnt      <= '0;
      post_cnt     <= '0;
      rd_cnt       <= '0;
      trig_offset  <= '0;
      sample_count <= '0;
    end else begin
      if (we) wr_ptr <= wr_ptr + AW'(1);
      if (armed) begin
        if (pre_cnt != PRE_MAX) pre_cnt <= pre_cnt + CNT_W'(1);
        if (trigger) begin
          trig_offset <= pre_cnt;
          post_cnt    <= POST_C;
        end
      end
      if (triggered) post_cnt <= post_cnt - CNT_W'(1);
      if (enter_done) begin
        sample_count <= sc_next;
        rd_ptr       <= wr_ptr + AW'(1) - sc_next[AW-1:0];
        rd_cnt       <= '0;
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + AW'(1);
        rd_cnt <= rd_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      rd_last  <= rd_accept && (rd_cnt == sample_count - CNT_W'(1));
    end
  end

  trace_capture_ram #(
    .W     (TRACE_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (trace),
    .re    (rd_accept),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule
